mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Sequences IF and DM requests onto the single MMU port; DM has priority, with a run limit so a pending fetch still gets through.
// Latency: grant 1 cycle after request, ack 1 cycle after mmu_done; requesters hold until ack, and mmu_* stay frozen until mmu_done.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_byte,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mmu_req,
    output logic              mmu_we,
    output logic              mmu_byte,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [DATA_W-1:0] mmu_wdata,
    input  logic [DATA_W-1:0] mmu_rdata,
    input  logic              mmu_done,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    localparam logic [2:0] RUN_MAX = 3'(MAX_D_RUN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_run_cnt;
    logic       w_if_elig;
    logic       w_dm_elig;
    logic       w_grant_if;
    logic       w_grant_dm;
    logic       w_done;

    // A request still held during its own ack cycle must not win a second grant.
    assign w_if_elig  = if_req & ~if_ack;
    assign w_dm_elig  = dm_req & ~dm_ack;
    assign w_grant_if = (r_state == S_IDLE) & w_if_elig & (~w_dm_elig | (r_run_cnt == RUN_MAX));
    assign w_grant_dm = (r_state == S_IDLE) & w_dm_elig & ~w_grant_if;
    assign w_done     = (r_state != S_IDLE) & mmu_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_dm) begin
                    w_state_nxt = S_BUSY_D;
                end else if (w_grant_if) begin
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mmu_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mmu_req   <= 1'b0;
            mmu_we    <= 1'b0;
            mmu_byte  <= 1'b0;
            mmu_addr  <= '0;
            mmu_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            r_run_cnt <= 3'd0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (w_grant_dm) begin
                mmu_req   <= 1'b1;
                mmu_we    <= dm_we;
                mmu_byte  <= dm_byte;
                mmu_addr  <= dm_addr;
                mmu_wdata <= dm_wdata;
                grant     <= 2'b10;
                busy      <= 1'b1;
                // Only data wins that actually held off a waiting fetch count toward the limit.
                if (!if_req) begin
                    r_run_cnt <= 3'd0;
                end else if (r_run_cnt != RUN_MAX) begin
                    r_run_cnt <= r_run_cnt + 3'd1;
                end
            end else if (w_grant_if) begin
                mmu_req   <= 1'b1;
                mmu_we    <= 1'b0;
                mmu_byte  <= 1'b0;
                mmu_addr  <= if_addr;
                grant     <= 2'b01;
                busy      <= 1'b1;
                r_run_cnt <= 3'd0;
            end else if (w_done) begin
                mmu_req <= 1'b0;
                grant   <= 2'b00;
                busy    <= 1'b0;
                if (r_state == S_BUSY_I) begin
                    if_rdata <= mmu_rdata;
                    if_ack   <= 1'b1;
                end else begin
                    if (!mmu_we) begin
                        dm_rdata <= mmu_rdata;
                    end
                    dm_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction-level reference checked every cycle,
// and literal expectations on key values and on the grant order under sustained data traffic.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, dm_byte;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mmu_addr, mmu_wdata, mmu_rdata;
    logic        if_ack, dm_ack, mmu_req, mmu_we, mmu_byte, mmu_done, busy;
    logic [1:0]  grant;

    // MMU stand-in: either automatic (done after done_dly cycles of mmu_req) or driven by hand.
    logic        resp_en = 1'b0;
    logic        man_done = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        auto_done = 1'b0;
    logic [31:0] auto_rdata = '0;
    int          done_dly = 1;
    int          rcnt = 0;

    assign mmu_done  = resp_en ? auto_done : man_done;
    assign mmu_rdata = resp_en ? auto_rdata : man_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mmu_req(mmu_req), .mmu_we(mmu_we), .mmu_byte(mmu_byte), .mmu_addr(mmu_addr),
        .mmu_wdata(mmu_wdata), .mmu_rdata(mmu_rdata), .mmu_done(mmu_done),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h3C08_DEAD;
        return a ^ 32'hA5A5_A5A5;
    endfunction

    always @(posedge clk) begin
        #2;
        if (!rst || !resp_en || auto_done || !mmu_req) begin
            rcnt      = 0;
            auto_done = 1'b0;
        end else begin
            rcnt++;
            if (rcnt >= done_dly) begin
                auto_done  = 1'b1;
                auto_rdata = mem_fn(mmu_addr);
            end
        end
    end

    // Reference: owner 0 = nobody, 1 = fetch, 2 = data; one transaction at a time.
    int          m_own = 0;
    int          m_run = 0;
    bit          m_if_ack = 0, m_dm_ack = 0, m_mwe = 0, m_mbyte = 0;
    logic [31:0] m_maddr = '0, m_mwdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    bit          m_if_ok, m_dm_ok;
    int          m_win;

    function automatic int pick(input bit want_i, input bit want_d, input int run);
        if (want_i && want_d) return (run == MAX) ? 1 : 2;
        if (want_d) return 2;
        if (want_i) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_own = 0; m_run = 0; m_if_ack = 0; m_dm_ack = 0; m_mwe = 0; m_mbyte = 0;
            m_maddr = '0; m_mwdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
        end else begin
            m_if_ok  = if_req && !m_if_ack;
            m_dm_ok  = dm_req && !m_dm_ack;
            m_if_ack = 0;
            m_dm_ack = 0;
            if (m_own == 0) begin
                m_win = pick(m_if_ok, m_dm_ok, m_run);
                if (m_win == 2) begin
                    m_maddr = dm_addr; m_mwe = dm_we; m_mbyte = dm_byte; m_mwdata = dm_wdata;
                    m_run = if_req ? ((m_run + 1 > MAX) ? MAX : m_run + 1) : 0;
                end else if (m_win == 1) begin
                    m_maddr = if_addr; m_mwe = 0; m_mbyte = 0; m_run = 0;
                end
                m_own = m_win;
            end else if (mmu_done) begin
                if (m_own == 1) begin
                    m_if_rdata = mmu_rdata; m_if_ack = 1;
                end else begin
                    if (!m_mwe) m_dm_rdata = mmu_rdata;
                    m_dm_ack = 1;
                end
                m_own = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    int gr_dut[64];
    int gr_mdl[64];
    int n_gr = 0, n_gm = 0;
    int prev_g = 0, prev_m = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mmu_req",   32'(mmu_req),   32'(m_own != 0));
            chk("mmu_we",    32'(mmu_we),    32'(m_mwe));
            chk("mmu_byte",  32'(mmu_byte),  32'(m_mbyte));
            chk("mmu_addr",  mmu_addr,       m_maddr);
            chk("mmu_wdata", mmu_wdata,      m_mwdata);
            chk("if_ack",    32'(if_ack),    32'(m_if_ack));
            chk("dm_ack",    32'(dm_ack),    32'(m_dm_ack));
            chk("if_rdata",  if_rdata,       m_if_rdata);
            chk("dm_rdata",  dm_rdata,       m_dm_rdata);
            chk("grant",     32'(grant),     32'(m_own));
            chk("busy",      32'(busy),      32'(m_own != 0));
            if (grant != 2'b00 && prev_g == 0 && n_gr < 64) begin
                gr_dut[n_gr] = int'(grant);
                n_gr++;
            end
            if (m_own != 0 && prev_m == 0 && n_gm < 64) begin
                gr_mdl[n_gm] = m_own;
                n_gm++;
            end
            prev_g = int'(grant);
            prev_m = m_own;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int sel);
        for (int i = 0; i < 60; i++) begin
            if ((sel == 1 ? if_ack : dm_ack) === 1'b1) return;
            tick(1);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_ack%0d: no ack within 60 cycles, required one", sel);
    endtask

    int base_d, base_m;
    int exp_seq[6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0000;
        dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = '0; dm_wdata = '0;
        man_done = 1'b1;
        tick(2);
        chk("rst_mmu_req", 32'(mmu_req), 32'd0);
        chk("rst_if_ack",  32'(if_ack),  32'd0);
        chk("rst_grant",   32'(grant),   32'd0);
        chk("rst_if_rd",   if_rdata,     32'd0);
        cmp_en = 1'b1;

        // Fetch after reset, then the same request held through its ack cycle.
        rst = 1'b1; man_done = 1'b0; resp_en = 1'b1; done_dly = 1;
        tick(1);
        chk("if1_addr",  mmu_addr,      32'h8000_0000);
        chk("if1_grant", 32'(grant),    32'd1);
        tick(1);
        chk("if1_ack",   32'(if_ack),   32'd1);
        chk("if1_rdata", if_rdata,      32'h3C08_DEAD);
        tick(1);
        chk("held_noreq", 32'(mmu_req), 32'd0);
        chk("held_ack0",  32'(if_ack),  32'd0);
        tick(1);
        chk("held_regrant", 32'(grant), 32'd1);
        wait_ack(1);
        if_req = 1'b0;
        tick(1);

        // Simultaneous requests: data store first, then the fetch.
        if_req = 1'b1; if_addr = 32'h8000_0004;
        dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1; dm_addr = 32'h8040_0010; dm_wdata = 32'h1234_5678;
        tick(1);
        chk("sim_grant", 32'(grant),    32'd2);
        chk("sim_we",    32'(mmu_we),   32'd1);
        chk("sim_byte",  32'(mmu_byte), 32'd1);
        chk("sim_addr",  mmu_addr,      32'h8040_0010);
        chk("sim_wdata", mmu_wdata,     32'h1234_5678);
        wait_ack(2);
        dm_req = 1'b0;
        chk("sim_dm_rd", dm_rdata, 32'd0);
        tick(1);
        chk("sim_if_grant", 32'(grant),  32'd1);
        chk("sim_if_we",    32'(mmu_we), 32'd0);
        chk("sim_if_wd",    mmu_wdata,   32'h1234_5678);
        wait_ack(1);
        if_req = 1'b0;
        chk("sim_if_rd", if_rdata, 32'h25A5_A5A1);
        tick(1);

        // Sustained data traffic: fetch withdrawn only in data-ack cycles.
        base_d = n_gr; base_m = n_gm;
        dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h8040_0100;
        if_req = 1'b1; if_addr = 32'h8000_0010;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (n_gr - base_d >= 6) break;
            if_req = ~dm_ack;
        end
        if_req = 1'b0;
        wait_ack(2);
        dm_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("starve_dut%0d", k), 32'(gr_dut[base_d + k]), 32'(exp_seq[k]));
            chk($sformatf("starve_mdl%0d", k), 32'(gr_mdl[base_m + k]), 32'(exp_seq[k]));
        end
        tick(2);

        // Slow MMU: request and payload frozen while the inputs move.
        done_dly = 6;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8040_0020; dm_wdata = 32'hCAFE_F00D;
        tick(1);
        chk("stall_addr0", mmu_addr, 32'h8040_0020);
        dm_addr = 32'h0; dm_wdata = 32'h0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk($sformatf("stall_req%0d", i),  32'(mmu_req), 32'd1);
            chk($sformatf("stall_addr%0d", i), mmu_addr,     32'h8040_0020);
            chk($sformatf("stall_wd%0d", i),   mmu_wdata,    32'hCAFE_F00D);
        end
        tick(1);
        chk("stall_ack1", 32'(dm_ack), 32'd1);
        dm_req = 1'b0;
        tick(1);
        chk("stall_ack0", 32'(dm_ack), 32'd0);

        // Reset during a data read, followed by a stray done.
        resp_en = 1'b0; man_done = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8040_0200;
        tick(1);
        chk("rmo_grant", 32'(grant), 32'd2);
        tick(2);
        chk("rmo_busy", 32'(busy), 32'd1);
        rst = 1'b0; dm_req = 1'b0;
        tick(1);
        chk("rmo_req0",  32'(mmu_req), 32'd0);
        chk("rmo_rd0",   dm_rdata,     32'd0);
        rst = 1'b1; man_done = 1'b1; man_rdata = 32'hFFFF_FFFF;
        tick(1);
        chk("rmo_noack", 32'(dm_ack),  32'd0);
        chk("rmo_idle",  32'(busy),    32'd0);
        man_done = 1'b0;
        tick(2);

        // Normal service resumes.
        resp_en = 1'b1; done_dly = 2;
        if_req = 1'b1; if_addr = 32'h8000_0020;
        tick(1);
        wait_ack(1);
        if_req = 1'b0;
        chk("rec_if_rd", if_rdata, 32'h25A5_A585);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
